// File: rtl/uc_mem_if.sv
// Memory bus between the microcode sequencer and a synchronous single-port RAM.
// Strobe bus without back-pressure: a transfer happens on every rising clk edge where
// mem_ce=1; mem_we selects write (1) or read (0); read data is valid the following cycle.
interface uc_mem_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W+1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_ce,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_ce,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/uc_sequencer.sv
// Microcoded control sequencer for a 4-instruction accumulator machine (NOR/ADD/STA/JCC).
// Drives the memory bus and the processing-unit strobes; state exposed on dbg_state.
module uc_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              carry,
  uc_mem_if.master          mem,
  output logic [2:0]        sel_UAL,
  output logic              load_R1,
  output logic              load_accu,
  output logic              load_carry,
  output logic              init_carry,
  output logic [ADDR_W-1:0] pc_out,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPREAD = 3'd2,
    S_LOADR  = 3'd3,
    S_EXEC   = 3'd4,
    S_STORE  = 3'd5
  } state_t;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W+1:0]   r_ir;
  logic                r_init_carry;
  logic                r_reissue;

  state_t              w_next_state;
  logic [ADDR_W-1:0]   w_next_pc;
  logic [ADDR_W+1:0]   w_next_ir;
  logic                w_next_init;
  logic                w_next_reissue;

  logic                w_en;
  logic [1:0]          w_op;
  logic [ADDR_W-1:0]   w_opa;
  logic [1:0]          w_rd_op;
  logic [ADDR_W-1:0]   w_rd_opa;

  logic [ADDR_W-1:0]   w_mem_addr;
  logic                w_mem_ce;
  logic                w_mem_we;

  // rst_n is folded into the strobe enable so nothing fires while reset is held.
  assign w_en     = ce & rst_n;
  assign w_op     = r_ir[ADDR_W+1:ADDR_W];
  assign w_opa    = r_ir[ADDR_W-1:0];
  assign w_rd_op  = mem.mem_rdata[ADDR_W+1:ADDR_W];
  assign w_rd_opa = mem.mem_rdata[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= '0;
      r_ir         <= '0;
      r_init_carry <= 1'b0;
      r_reissue    <= 1'b0;
    end else if (ce) begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      r_ir         <= w_next_ir;
      r_init_carry <= w_next_init;
      r_reissue    <= w_next_reissue;
    end else if (r_state == S_DECODE) begin
      // The fetch data may be lost across a stall, so DECODE re-reads before latching.
      r_reissue    <= 1'b1;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_next_ir      = r_ir;
    w_next_init    = 1'b0;
    w_next_reissue = r_reissue;
    case (r_state)
      S_FETCH: begin
        w_next_state   = S_DECODE;
        w_next_reissue = 1'b0;
      end
      S_DECODE: begin
        if (r_reissue) begin
          w_next_reissue = 1'b0;
        end else begin
          w_next_ir = mem.mem_rdata;
          w_next_pc = r_pc + ADDR_W'(1);
          case (w_rd_op)
            OP_NOR, OP_ADD: w_next_state = S_OPREAD;
            OP_STA:         w_next_state = S_STORE;
            default: begin
              w_next_state = S_FETCH;
              if (!carry) w_next_pc   = w_rd_opa;
              else        w_next_init = 1'b1;
            end
          endcase
        end
      end
      S_OPREAD: w_next_state = S_LOADR;
      S_LOADR:  w_next_state = S_EXEC;
      S_EXEC:   w_next_state = S_FETCH;
      S_STORE:  w_next_state = S_FETCH;
      default:  w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_mem_addr = r_pc;
    w_mem_ce   = 1'b0;
    w_mem_we   = 1'b0;
    sel_UAL    = 3'b000;
    load_R1    = 1'b0;
    load_accu  = 1'b0;
    load_carry = 1'b0;
    case (r_state)
      S_FETCH:  w_mem_ce = w_en;
      S_DECODE: w_mem_ce = w_en & r_reissue;
      S_OPREAD: begin
        w_mem_addr = w_opa;
        w_mem_ce   = w_en;
      end
      S_LOADR:  load_R1 = w_en;
      S_EXEC: begin
        if (w_op == OP_NOR)      sel_UAL = 3'b001;
        else if (w_op == OP_ADD) sel_UAL = 3'b010;
        load_accu  = w_en;
        load_carry = w_en & (w_op == OP_ADD);
      end
      S_STORE: begin
        w_mem_addr = w_opa;
        w_mem_ce   = w_en;
        w_mem_we   = w_en;
      end
      default: ;
    endcase
  end

  assign mem.mem_addr = w_mem_addr;
  assign mem.mem_ce   = w_mem_ce;
  assign mem.mem_we   = w_mem_we;
  assign init_carry   = r_init_carry & w_en;
  assign pc_out       = r_pc;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_uc_sequencer.sv
// Bench for uc_sequencer: directed cycle-accurate scenarios, then random programs with
// random stalls checked against an instruction-level model of the machine.
module tb_uc_sequencer;
  localparam int ADDR_W = 6;
  localparam int DW     = ADDR_W + 2;
  localparam int MEM_N  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ce = 1'b0;
  logic              carry_force = 1'b0;
  logic              carry_in;
  logic [2:0]        sel_UAL;
  logic              load_R1, load_accu, load_carry, init_carry;
  logic [ADDR_W-1:0] pc_out;
  logic [2:0]        dbg_state;

  uc_mem_if #(.ADDR_W(ADDR_W)) mem_bus ();

  uc_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ce         (ce),
    .carry      (carry_in),
    .mem        (mem_bus),
    .sel_UAL    (sel_UAL),
    .load_R1    (load_R1),
    .load_accu  (load_accu),
    .load_carry (load_carry),
    .init_carry (init_carry),
    .pc_out     (pc_out),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory and processing unit environment
  logic [DW-1:0] mem  [MEM_N];
  logic [DW-1:0] prog [MEM_N];
  logic [DW-1:0] rdata_q;
  logic          load_prog = 1'b0;
  logic [DW-1:0] pu_r1, pu_accu;
  logic          pu_carry;
  logic [DW:0]   pu_sum;

  assign mem_bus.mem_rdata = rdata_q;
  assign carry_in = pu_carry | carry_force;
  assign pu_sum = {1'b0, pu_accu} + {1'b0, pu_r1};

  always @(posedge clk) begin
    if (load_prog) begin
      mem     <= prog;
      rdata_q <= '0;
    end else if (mem_bus.mem_ce) begin
      if (mem_bus.mem_we) mem[mem_bus.mem_addr] <= pu_accu;
      else                rdata_q <= mem[mem_bus.mem_addr];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pu_r1    <= '0;
      pu_accu  <= '0;
      pu_carry <= 1'b0;
    end else begin
      if (load_R1) pu_r1 <= rdata_q;
      if (load_accu) begin
        if (sel_UAL == 3'b001)      pu_accu <= ~(pu_accu | pu_r1);
        else if (sel_UAL == 3'b010) pu_accu <= pu_sum[DW-1:0];
      end
      if (load_carry) pu_carry <= pu_sum[DW];
      if (init_carry) pu_carry <= 1'b0;
    end
  end

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  int n_bus   = 0;
  logic mon_on = 1'b0;
  logic [ADDR_W+DW:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] pk(input logic c, input logic w, input logic r1,
                                     input logic la, input logic lc, input logic ic,
                                     input logic [2:0] sel, input logic [5:0] a);
    return {c, w, r1, la, lc, ic, sel, a};
  endfunction

  function automatic logic [14:0] ob();
    return {mem_bus.mem_ce, mem_bus.mem_we, load_R1, load_accu, load_carry, init_carry,
            sel_UAL, mem_bus.mem_addr};
  endfunction

  task automatic step_chk(input string tag, input logic [14:0] exp);
    @(negedge clk);
    check(tag, {17'd0, ob()}, {17'd0, exp});
  endtask

  task automatic now_chk(input string tag, input logic [14:0] exp);
    #1;
    check(tag, {17'd0, ob()}, {17'd0, exp});
  endtask

  // instruction-level reference model
  logic [DW-1:0]     m_mem [MEM_N];
  logic [ADDR_W-1:0] m_pc;
  logic [DW-1:0]     m_accu;
  logic              m_c;

  task automatic model_step();
    logic [DW-1:0]     w;
    logic [ADDR_W-1:0] a;
    logic [DW:0]       s;
    w = m_mem[m_pc];
    a = w[ADDR_W-1:0];
    exp_q.push_back({1'b0, m_pc, {DW{1'b0}}});
    m_pc = m_pc + 1'b1;
    case (w[DW-1:DW-2])
      2'b00: begin
        exp_q.push_back({1'b0, a, {DW{1'b0}}});
        m_accu = ~(m_accu | m_mem[a]);
      end
      2'b01: begin
        exp_q.push_back({1'b0, a, {DW{1'b0}}});
        s = {1'b0, m_accu} + {1'b0, m_mem[a]};
        m_accu = s[DW-1:0];
        m_c = s[DW];
      end
      2'b10: begin
        exp_q.push_back({1'b1, a, m_accu});
        m_mem[a] = m_accu;
      end
      default: begin
        if (!m_c) m_pc = a;
        else      m_c = 1'b0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    logic [ADDR_W+DW:0] obs, exp;
    if (mon_on) begin
      if (!ce)
        check("stall_quiet", {26'd0, mem_bus.mem_ce, mem_bus.mem_we, load_R1, load_accu,
                              load_carry, init_carry}, 32'd0);
      if (load_R1 || load_accu || mem_bus.mem_we)
        check("strobe_excl", 32'(load_R1) + 32'(load_accu) + 32'(mem_bus.mem_we), 32'd1);
      if (mem_bus.mem_ce) begin
        obs = {mem_bus.mem_we, mem_bus.mem_addr,
               mem_bus.mem_we ? pu_accu : {DW{1'b0}}};
        if (exp_q.size() == 0) model_step();
        exp = exp_q.pop_front();
        n_bus++;
        check("bus_xfer", 32'(obs), 32'(exp));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // directed program
    for (int i = 0; i < MEM_N; i++) prog[i] = '0;
    prog[0]  = 8'h45;  // ADD 5
    prog[5]  = 8'h03;
    prog[1]  = 8'h8A;  // STA 10
    prog[2]  = 8'hE0;  // JCC 32
    prog[32] = 8'hE0;  // JCC 32
    prog[33] = 8'hFF;  // JCC 63
    prog[63] = 8'h01;  // NOR 1
    rst_n = 1'b0;
    ce = 1'b1;
    load_prog = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load_prog = 1'b0;
    check("rst_outputs", {17'd0, ob()}, 32'd0);
    check("rst_pc", 32'(pc_out), 32'd0);
    rst_n = 1'b1;
    now_chk("fetch_pc0", pk(1,0,0,0,0,0,3'b000,0));
    step_chk("add_decode", pk(0,0,0,0,0,0,3'b000,0));
    step_chk("add_opread", pk(1,0,0,0,0,0,3'b000,5));
    check("pc_after_decode", 32'(pc_out), 32'd1);
    step_chk("add_loadr", pk(0,0,1,0,0,0,3'b000,1));
    step_chk("add_exec", pk(0,0,0,1,1,0,3'b010,1));
    step_chk("fetch_pc1", pk(1,0,0,0,0,0,3'b000,1));
    step_chk("sta_decode", pk(0,0,0,0,0,0,3'b000,1));
    step_chk("sta_store", pk(1,1,0,0,0,0,3'b000,10));
    step_chk("fetch_pc2", pk(1,0,0,0,0,0,3'b000,2));
    check("sta_data", 32'(mem[10]), 32'h03);
    step_chk("jcc_decode_c0", pk(0,0,0,0,0,0,3'b000,2));
    step_chk("jcc_taken_fetch", pk(1,0,0,0,0,0,3'b000,32));
    step_chk("jcc_decode_c1", pk(0,0,0,0,0,0,3'b000,32));
    carry_force = 1'b1;
    step_chk("jcc_not_taken", pk(1,0,0,0,0,1,3'b000,33));
    carry_force = 1'b0;
    step_chk("jcc63_decode", pk(0,0,0,0,0,0,3'b000,33));
    step_chk("fetch_pc63", pk(1,0,0,0,0,0,3'b000,63));
    step_chk("nor_decode", pk(0,0,0,0,0,0,3'b000,63));
    step_chk("nor_opread", pk(1,0,0,0,0,0,3'b000,1));
    check("pc_wrap", 32'(pc_out), 32'd0);
    @(negedge clk);
    ce = 1'b0;
    now_chk("stall_loadr0", pk(0,0,0,0,0,0,3'b000,0));
    step_chk("stall_loadr1", pk(0,0,0,0,0,0,3'b000,0));
    step_chk("stall_loadr2", pk(0,0,0,0,0,0,3'b000,0));
    ce = 1'b1;
    now_chk("resume_loadr", pk(0,0,1,0,0,0,3'b000,0));
    step_chk("nor_exec", pk(0,0,0,1,0,0,3'b001,0));
    step_chk("wrap_fetch0", pk(1,0,0,0,0,0,3'b000,0));
    step_chk("add2_decode", pk(0,0,0,0,0,0,3'b000,0));
    step_chk("add2_opread", pk(1,0,0,0,0,0,3'b000,5));
    step_chk("add2_loadr", pk(0,0,1,0,0,0,3'b000,1));
    step_chk("add2_exec", pk(0,0,0,1,1,0,3'b010,1));
    rst_n = 1'b0;
    now_chk("rst_in_exec", pk(0,0,0,0,0,0,3'b000,0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    now_chk("fetch_after_rst", pk(1,0,0,0,0,0,3'b000,0));
    @(negedge clk);
    ce = 1'b0;
    now_chk("stall_decode0", pk(0,0,0,0,0,0,3'b000,0));
    step_chk("stall_decode1", pk(0,0,0,0,0,0,3'b000,0));
    ce = 1'b1;
    now_chk("reissue_read", pk(1,0,0,0,0,0,3'b000,0));
    step_chk("decode_after_reissue", pk(0,0,0,0,0,0,3'b000,0));
    step_chk("opread_after_reissue", pk(1,0,0,0,0,0,3'b000,5));
    check("pc_after_reissue", 32'(pc_out), 32'd1);

    // random programs with random stalls
    for (int run = 0; run < 3; run++) begin
      @(negedge clk);
      mon_on = 1'b0;
      rst_n = 1'b0;
      ce = 1'b1;
      for (int i = 0; i < MEM_N; i++) begin
        prog[i]  = DW'($urandom_range(0, (1 << DW) - 1));
        m_mem[i] = prog[i];
      end
      m_pc = '0;
      m_accu = '0;
      m_c = 1'b0;
      exp_q.delete();
      load_prog = 1'b1;
      @(negedge clk);
      @(negedge clk);
      load_prog = 1'b0;
      rst_n = 1'b1;
      mon_on = 1'b1;
      for (int cyc = 0; cyc < 1000; cyc++) begin
        @(negedge clk);
        #1;
        if (dbg_state == 3'd1) ce = 1'b1;
        else ce = ($urandom_range(0, 3) != 0);
      end
    end
    @(negedge clk);
    mon_on = 1'b0;
    check("bus_activity", 32'(n_bus > 600), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_sequencer.md
UC_SEQUENCER -- requirements
Module: uc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, memory address width in bits; the instruction word is 2+ADDR_W bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ce  input  1  clock enable; 0 freezes all state.
REQ-005 SHALL have port carry  input  1  carry flag from the processing unit.
REQ-006 SHALL have port mem_rdata  input  2+ADDR_W  memory read data, valid one cycle after a read with mem_ce=1 and mem_we=0.
REQ-007 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-008 SHALL have port mem_ce  output  1  memory access strobe.
REQ-009 SHALL have port mem_we  output  1  memory write strobe, valid only with mem_ce=1.
REQ-010 SHALL have port sel_UAL  output  3  ALU operation select.
REQ-011 SHALL have ports load_R1, load_accu, load_carry, init_carry  output  1 each  single-cycle processing-unit strobes.
REQ-012 SHALL have port pc_out  output  ADDR_W  current program counter, for debug.

Function
REQ-013 Instruction word SHALL be opcode = bits[ADDR_W+1:ADDR_W] and operand address = bits[ADDR_W-1:0].
REQ-014 Opcodes SHALL be 00 NOR (accu <= ~(accu|mem[a])), 01 ADD (accu <= accu+mem[a], carry updated), 10 STA (mem[a] <= accu), 11 JCC (if carry=0 then PC <= a, else carry cleared).
REQ-015 sel_UAL SHALL be 3'b001 for NOR, 3'b010 for ADD and 3'b000 otherwise.
REQ-016 FSM states SHALL be FETCH, DECODE, OPREAD, LOADR, EXEC and STORE.
REQ-017 FETCH SHALL drive mem_addr=PC with mem_ce=1 and mem_we=0, then go to DECODE.
REQ-018 DECODE SHALL latch mem_rdata into IR and increment PC modulo 2^ADDR_W (wrapping from all-ones to 0).
REQ-019 From DECODE, opcodes 00 and 01 SHALL go to OPREAD, 10 to STORE and 11 to FETCH.
REQ-020 In DECODE with opcode 11, the block SHALL load PC with the operand address when carry=0; when carry=1 it SHALL pulse init_carry and keep the incremented PC.
REQ-021 OPREAD SHALL drive mem_addr=IR operand address with mem_ce=1 and mem_we=0, then go to LOADR.
REQ-022 LOADR SHALL pulse load_R1 for one cycle, then go to EXEC.
REQ-023 EXEC SHALL drive sel_UAL per opcode, pulse load_accu, and pulse load_carry for ADD only; it then goes to FETCH.
REQ-024 STORE SHALL drive mem_addr=IR operand address with mem_ce=1 and mem_we=1 for one cycle, then go to FETCH.
REQ-025 Cycles per instruction SHALL be: NOR/ADD 5, STA 3, JCC 2.
REQ-026 All outputs SHALL be registered or decoded only from the state and IR registers, never combinationally from mem_rdata or carry (the init_carry decision is registered from carry sampled in DECODE).
REQ-027 While ce=0, state, PC and IR SHALL hold, and all strobes (mem_ce, mem_we, load_*, init_carry) SHALL be 0.
REQ-028 When ce returns to 1, the FSM SHALL resume the held state exactly; a memory read issued before the stall SHALL be re-issued on resume.
REQ-029 At most one of load_R1, load_accu and mem_we SHALL be asserted in any cycle.
REQ-030 When mem_addr is not driving a memory access, it SHALL show PC.

Reset
REQ-031 With rst_n=0 the block SHALL asynchronously enter FETCH with PC=0 and IR=0.
REQ-032 During reset all strobes SHALL be 0, sel_UAL SHALL be 3'b000, and mem_addr and pc_out SHALL be 0.
REQ-033 Reset asserted mid-instruction SHALL abort it with no further strobes.
REQ-034 The first fetch after reset SHALL occur on the first rising clk edge where rst_n=1 and ce=1.

Verification
REQ-035 Scenario: mem[0]=8'h45 (ADD 5), mem[5]=8'h03, accu=0 -> mem_ce at PC 0, then at address 5, then load_R1, then load_accu+load_carry with sel_UAL=010; 5 cycles total; PC=1.
REQ-036 Scenario: mem[1]=8'h8A (STA 10) -> mem_ce=1, mem_we=1, mem_addr=10 for exactly one cycle, 3 cycles from fetch.
REQ-037 Scenario: JCC 8'hE0 with carry=0 -> next fetch at address 32; with carry=1 -> init_carry pulse and next fetch at PC+1.
REQ-038 Scenario: PC=63 executing NOR -> next fetch at address 0 (wrap-around).
REQ-039 Scenario: ce=0 for 3 cycles during LOADR -> no strobes while stalled; load_R1 pulses on the first ce=1 cycle; subsequent timing is unchanged.
REQ-040 Scenario: rst_n pulled low during EXEC -> load_accu deasserts immediately; after release the first fetch is at address 0.
